ipml_frame_fifo_ovl: RTL and testbench

//   Overlapping-frame sample buffer for the audio framing path. Accepts a continuous sample

---
 rtl/ipml_frame_fifo_ovl.sv | 159 +++++++++++++++
 tb/tb_ipml_frame_fifo_ovl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipml_frame_fifo_ovl.sv
// Overlapping-frame sample buffer: a circular RAM written as a stream and read back as
// FRAME_LEN-sample frames whose start points advance by HOP_LEN.
module ipml_frame_fifo_ovl #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DEPTH_WIDTH = 11,
    parameter int unsigned FRAME_LEN   = 1024,
    parameter int unsigned HOP_LEN     = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic [DEPTH_WIDTH:0]  fill_level,
    output logic [15:0]           frame_cnt,
    output logic                  overflow
);
    localparam int unsigned DEPTH = 2 ** DEPTH_WIDTH;
    localparam int unsigned PW    = DEPTH_WIDTH + 1;
    localparam int unsigned IW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic {IDLE, READ} state_t;

    state_t                  state, state_n;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [PW-1:0]           wp, fb, wp_n, fb_n, fill_n;
    logic [IW-1:0]           idx;
    logic                    issued_all;
    logic [DATA_WIDTH-1:0]   ram_q, skid_data;
    logic                    rd_vld, rd_sof, rd_eof;
    logic                    skid_vld, skid_sof, skid_eof;
    logic                    wr, pop, rel, issue, iss_sof, iss_eof, room;
    logic [1:0]              occ;
    logic [DEPTH_WIDTH-1:0]  raddr;

    // Next-state, read issue and pointer arithmetic
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        rel     = 1'b0;
        wr      = in_valid & in_ready;
        pop     = out_valid & out_ready;
        // Reads in flight plus held samples must never exceed the output + skid slots.
        occ     = 2'(out_valid) + 2'(skid_vld) + 2'(rd_vld);
        room    = (occ - 2'(pop)) <= 2'd1;
        case (state)
            IDLE: begin
                if (fill_level >= PW'(FRAME_LEN)) begin
                    issue   = 1'b1;
                    state_n = READ;
                end
            end
            READ: begin
                issue = !issued_all && room;
                if (pop && out_eof) begin
                    rel     = 1'b1;
                    state_n = IDLE;
                end
            end
        endcase
        iss_sof = (idx == '0);
        iss_eof = (idx == IW'(FRAME_LEN - 1));
        raddr   = fb[DEPTH_WIDTH-1:0] + DEPTH_WIDTH'(idx);
        wp_n    = wp + PW'(wr);
        fb_n    = rel ? fb + PW'(HOP_LEN) : fb;
        fill_n  = wp_n - fb_n;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) state <= IDLE;
        else              state <= state_n;
    end

    // Simple dual-port RAM with registered read
    always_ff @(posedge clk) begin
        if (wr)    mem[wp[DEPTH_WIDTH-1:0]] <= in_data;
        if (issue) ram_q <= mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp         <= '0;
            fb         <= '0;
            fill_level <= '0;
            in_ready   <= 1'b1;
            idx        <= '0;
            issued_all <= 1'b0;
            rd_vld     <= 1'b0;
            rd_sof     <= 1'b0;
            rd_eof     <= 1'b0;
            skid_vld   <= 1'b0;
            skid_sof   <= 1'b0;
            skid_eof   <= 1'b0;
            skid_data  <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_data   <= '0;
            if (rst) begin
                frame_cnt <= '0;
                overflow  <= 1'b0;
            end
        end else begin
            if (in_valid && !in_ready) overflow <= 1'b1;
            wp         <= wp_n;
            fb         <= fb_n;
            fill_level <= fill_n;
            in_ready   <= fill_n < PW'(DEPTH);

            if (rel) begin
                frame_cnt  <= frame_cnt + 16'd1;
                idx        <= '0;
                issued_all <= 1'b0;
            end else if (issue) begin
                if (iss_eof) issued_all <= 1'b1;
                else         idx <= idx + IW'(1);
            end

            rd_vld <= issue;
            rd_sof <= issue & iss_sof;
            rd_eof <= issue & iss_eof;

            // Output stage with one-entry skid to absorb the RAM read latency
            if (pop) begin
                if (skid_vld) begin
                    out_data  <= skid_data;
                    out_sof   <= skid_sof;
                    out_eof   <= skid_eof;
                    out_valid <= 1'b1;
                    skid_vld  <= rd_vld;
                    skid_sof  <= rd_sof;
                    skid_eof  <= rd_eof;
                    skid_data <= ram_q;
                end else begin
                    out_valid <= rd_vld;
                    out_sof   <= rd_sof;
                    out_eof   <= rd_eof;
                    out_data  <= ram_q;
                end
            end else if (!out_valid) begin
                out_valid <= rd_vld;
                out_sof   <= rd_sof;
                out_eof   <= rd_eof;
                out_data  <= ram_q;
            end else if (rd_vld) begin
                skid_vld  <= 1'b1;
                skid_sof  <= rd_sof;
                skid_eof  <= rd_eof;
                skid_data <= ram_q;
            end
        end
    end
endmodule

// File: tb/tb_ipml_frame_fifo_ovl.sv
// Bench for ipml_frame_fifo_ovl: scenario tasks plus a stream scoreboard that predicts every
// frame sample from the list of accepted input samples.
module tb_ipml_frame_fifo_ovl;
    localparam int FL  = 8;
    localparam int HOP = 4;
    localparam int DEP = 16;

    logic        clk;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_sof, out_eof, overflow;
    logic [15:0] in_data, out_data, frame_cnt;
    logic [4:0]  fill_level;

    logic        rst2, flush2, in_valid2, in_ready2, out_valid2, out_ready2, out_sof2, out_eof2;
    logic        overflow2;
    logic [15:0] in_data2, out_data2, frame_cnt2;
    logic [4:0]  fill_level2;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] acc[$];
    int          rel, pos;
    logic [15:0] fcnt;
    bit          ovf, mon_on, stall_prev, prev_sof, prev_eof;
    logic [15:0] prev_data;

    ipml_frame_fifo_ovl #(.DATA_WIDTH(16), .DEPTH_WIDTH(4), .FRAME_LEN(FL), .HOP_LEN(HOP)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof), .fill_level(fill_level), .frame_cnt(frame_cnt),
        .overflow(overflow));

    ipml_frame_fifo_ovl #(.DATA_WIDTH(16), .DEPTH_WIDTH(4), .FRAME_LEN(8), .HOP_LEN(8)) dut2 (
        .clk(clk), .rst(rst2), .flush(flush2), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_sof(out_sof2), .out_eof(out_eof2), .fill_level(fill_level2), .frame_cnt(frame_cnt2),
        .overflow(overflow2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic rdy(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 2) == 0;
            2:       return $urandom_range(0, 1) == 1;
            default: return 1'b0;
        endcase
    endfunction

    // Frame k is accepted samples [k*HOP .. k*HOP+FL-1]; predicts flags, fill and counters.
    task automatic test_scoreboard();
        int ef, k;
        forever begin
            @(negedge clk);
            ef = acc.size() - rel * HOP;
            if (mon_on) begin
                total++;
                if (fill_level !== 5'(ef)) begin
                    bad++; $display("FAIL sb_fill: got %0d want %0d", fill_level, ef);
                end
                total++;
                if (in_ready !== 1'(ef < DEP)) begin
                    bad++; $display("FAIL sb_in_ready: got %0b want %0b", in_ready, ef < DEP);
                end
                total++;
                if (frame_cnt !== fcnt || overflow !== ovf) begin
                    bad++;
                    $display("FAIL sb_counters: got cnt=%0d ovf=%0b want cnt=%0d ovf=%0b",
                             frame_cnt, overflow, fcnt, ovf);
                end
                if (stall_prev) begin
                    total++;
                    if (out_valid !== 1'b1 || out_data !== prev_data || out_sof !== prev_sof ||
                        out_eof !== prev_eof) begin
                        bad++;
                        $display("FAIL sb_hold: got v=%0b d=%0d sof=%0b eof=%0b want v=1 d=%0d sof=%0b eof=%0b",
                                 out_valid, out_data, out_sof, out_eof, prev_data, prev_sof, prev_eof);
                    end
                end
                if (out_valid === 1'b1) begin
                    k = rel * HOP + pos;
                    total++;
                    if (k >= acc.size()) begin
                        bad++; $display("FAIL sb_underrun: got index %0d want below %0d", k, acc.size());
                    end else if (out_data !== acc[k] || out_sof !== 1'(pos == 0) ||
                                 out_eof !== 1'(pos == FL - 1)) begin
                        bad++;
                        $display("FAIL sb_data: got d=%0d sof=%0b eof=%0b want d=%0d sof=%0b eof=%0b",
                                 out_data, out_sof, out_eof, acc[k], pos == 0, pos == FL - 1);
                    end
                end
            end
            if (rst) begin
                acc.delete(); rel = 0; pos = 0; fcnt = '0; ovf = 0; stall_prev = 0; mon_on = 1;
            end else if (flush) begin
                acc.delete(); rel = 0; pos = 0; stall_prev = 0;
            end else if (mon_on) begin
                if (in_valid) begin
                    if (ef < DEP) acc.push_back(in_data);
                    else          ovf = 1;
                end
                if (out_valid && out_ready) begin
                    if (pos == FL - 1) begin
                        pos = 0; rel++; fcnt = fcnt + 16'd1;
                    end else begin
                        pos++;
                    end
                end
                stall_prev = out_valid && !out_ready;
                prev_data  = out_data;
                prev_sof   = out_sof;
                prev_eof   = out_eof;
            end
        end
    endtask

    // Entry/exit point of every task below: 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic push_samples(input int n, input int base, input bit gaps, input bit rnd,
                                input int mode, output bit ok);
        int sent = 0;
        for (int c = 0; c < 4000 && sent < n; c++) begin
            in_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data   = rnd ? 16'($urandom) : 16'(base + sent);
            out_ready = rdy(mode, c);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ok = (sent == n);
    endtask

    task automatic wait_frames(input int target, input int mode, output bit ok);
        ok = 0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            out_ready = rdy(mode, c);
            @(negedge clk);
            ok = (frame_cnt == 16'(target));
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        total++; if (out_sof !== 1'b0 || out_eof !== 1'b0) begin bad++; $display("FAIL reset_flags: got %0b%0b want 00", out_sof, out_eof); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        total++; if (fill_level !== 5'd0) begin bad++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        int f = -1, v = -1, nv = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < FL; i++) begin
            in_valid = 1'b1; in_data = 16'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (f < 0 && fill_level >= 5'(FL)) f = c;
            if (v < 0 && out_valid) v = c;
            if (v >= 0 && c < v + FL && out_valid) nv++;
            @(posedge clk); #1;
        end
        total++; if (f != 0) begin bad++; $display("FAIL lat_fill_cycle: got %0d want 0", f); end
        total++; if (v - f != 2) begin bad++; $display("FAIL lat_first_valid: got %0d want 2", v - f); end
        total++; if (nv != FL) begin bad++; $display("FAIL lat_no_bubbles: got %0d want %0d", nv, FL); end
        total++; if (frame_cnt !== 16'd1 || fill_level !== 5'd4) begin
            bad++; $display("FAIL lat_end: got cnt=%0d fill=%0d want cnt=1 fill=4", frame_cnt, fill_level);
        end
    endtask

    task automatic test_basic_overlap();
        bit ok;
        do_reset();
        push_samples(16, 0, 0, 0, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_push: got timeout want 16 accepted"); end
        wait_frames(3, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_frames: got %0d want 3", frame_cnt); end
        repeat (4) @(posedge clk);
        #1;
        total++; if (fill_level !== 5'd4 || out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_end: got fill=%0d v=%0b want fill=4 v=0", fill_level, out_valid);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        push_samples(16, 0, 0, 0, 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_push: got timeout want 16 accepted"); end
        wait_frames(3, 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_frames: got %0d want 3", frame_cnt); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_overflow: got %0b want 0", overflow); end
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 16'(i);
            @(negedge clk);
            if (i == 16) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready_after16: got %0b want 0", in_ready); end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (fill_level !== 5'd16) begin bad++; $display("FAIL ovf_fill: got %0d want 16", fill_level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
        @(posedge clk); #1;
        wait_frames(3, 0, ok);
        total++; if (!ok || fill_level !== 5'd4) begin
            bad++; $display("FAIL ovf_drain: got cnt=%0d fill=%0d want cnt=3 fill=4", frame_cnt, fill_level);
        end
    endtask

    task automatic test_flush();
        bit ok;
        push_samples(6, 200, 0, 0, 3, ok);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || fill_level !== 5'd0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_clear: got v=%0b fill=%0d rdy=%0b want v=0 fill=0 rdy=1", out_valid, fill_level, in_ready);
        end
        total++; if (frame_cnt !== 16'd3 || overflow !== 1'b1) begin
            bad++; $display("FAIL flush_keep: got cnt=%0d ovf=%0b want cnt=3 ovf=1", frame_cnt, overflow);
        end
        @(posedge clk); #1;
        push_samples(8, 50, 0, 0, 0, ok);
        wait_frames(4, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL flush_refill: got %0d want 4", frame_cnt); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        push_samples(64, 0, 1, 1, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_push: got timeout want 64 accepted"); end
        wait_frames(15, 0, ok);
        total++; if (!ok || fill_level !== 5'd4) begin
            bad++; $display("FAIL wrap_frames: got cnt=%0d fill=%0d want cnt=15 fill=4", frame_cnt, fill_level);
        end
    endtask

    task automatic test_random();
        bit ok;
        do_reset();
        push_samples(40, 0, 1, 1, 2, ok);
        total++; if (!ok) begin bad++; $display("FAIL rand_push: got timeout want 40 accepted"); end
        wait_frames(9, 2, ok);
        total++; if (!ok || fill_level !== 5'd4) begin
            bad++; $display("FAIL rand_frames: got cnt=%0d fill=%0d want cnt=9 fill=4", frame_cnt, fill_level);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok, seen = 0;
        int pops = 0;
        do_reset();
        push_samples(8, 0, 0, 0, 3, ok);
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = out_valid;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid) pops++;
            @(posedge clk); #1;
        end
        total++; if (pops != 3) begin bad++; $display("FAIL mid_pops: got %0d want 3", pops); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || fill_level !== 5'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL mid_reset: got v=%0b fill=%0d ovf=%0b want 0 0 0", out_valid, fill_level, overflow);
        end
        @(posedge clk); #1;
        push_samples(8, 100, 0, 0, 0, ok);
        wait_frames(1, 0, ok);
        total++; if (!ok || fill_level !== 5'd4) begin
            bad++; $display("FAIL mid_newframe: got cnt=%0d fill=%0d want cnt=1 fill=4", frame_cnt, fill_level);
        end
    endtask

    task automatic test_no_overlap();
        logic [15:0] gd[$];
        bit          gs[$], ge[$];
        int          sent = 0;
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        for (int c = 0; c < 300 && gd.size() < 24; c++) begin
            in_valid2 = (sent < 24);
            in_data2  = 16'(sent);
            @(negedge clk);
            if (in_valid2 && in_ready2) sent++;
            if (out_valid2 && out_ready2) begin
                gd.push_back(out_data2); gs.push_back(out_sof2); ge.push_back(out_eof2);
            end
            @(posedge clk); #1;
        end
        in_valid2 = 1'b0;
        total++; if (gd.size() != 24) begin bad++; $display("FAIL nov_count: got %0d want 24", gd.size()); end
        for (int i = 0; i < gd.size(); i++) begin
            total++;
            if (gd[i] !== 16'(i) || gs[i] !== 1'(i % 8 == 0) || ge[i] !== 1'(i % 8 == 7)) begin
                bad++;
                $display("FAIL nov_sample%0d: got d=%0d sof=%0b eof=%0b want d=%0d sof=%0b eof=%0b",
                         i, gd[i], gs[i], ge[i], i, i % 8 == 0, i % 8 == 7);
            end
        end
        @(negedge clk);
        total++; if (frame_cnt2 !== 16'd3 || fill_level2 !== 5'd0) begin
            bad++; $display("FAIL nov_end: got cnt=%0d fill=%0d want cnt=3 fill=0", frame_cnt2, fill_level2);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rst2 = 1'b1; flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
        rel = 0; pos = 0; fcnt = '0; ovf = 0; mon_on = 0; stall_prev = 0;
        prev_data = '0; prev_sof = 0; prev_eof = 0;
        fork
            test_scoreboard();
        join_none
        test_reset();
        test_latency();
        test_basic_overlap();
        test_backpressure();
        test_overflow();
        test_flush();
        test_wrap();
        test_random();
        test_reset_mid_frame();
        test_no_overlap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
